// File: rtl/if_pc_sequencer_pkg.sv
// Shared IF-stage definitions: FSM encodings, reset/step/NOP defaults and PC arithmetic.
package if_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
  localparam logic [15:0] DEF_PC_STEP   = 16'd4;
  localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;

  // PC sums deliberately wrap modulo 2^16.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc, input logic [15:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/if_pc_sequencer_if.sv
// Fetch-stage bus bundle: redirect/stall control, instruction memory port and IF/ID register.
interface if_pc_sequencer_if;
  // imem: a fetch completes in any cycle where imem_req & imem_ready; imem_rdata is valid
  // only then. An address change (redirect) may abandon a request that never saw ready.
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;
  logic [15:0] ifid_instr;

  modport master (
    input  redirect_valid, redirect_target, stall, imem_ready, imem_rdata,
    output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_pc_next, ifid_instr
  );

  modport slave (
    output redirect_valid, redirect_target, stall, imem_ready, imem_rdata,
    input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_pc_next, ifid_instr
  );
endinterface

// File: rtl/if_pc_sequencer_skid.sv
// One-entry {pc,instr} holding register for a fetch that completed while ID was stalled.
module if_pc_sequencer_skid (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] load_pc,
  input  logic [15:0] load_instr,
  output logic        valid,
  output logic [15:0] pc,
  output logic [15:0] instr
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid <= 1'b0;
      pc    <= 16'h0000;
      instr <= 16'h0000;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/if_pc_sequencer.sv
// Fetch-stage PC owner: sequences fetches, absorbs ID stalls via a skid entry, applies redirects.
module if_pc_sequencer
  import if_pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [15:0] PC_STEP   = DEF_PC_STEP,
  parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                      clock,
  input  logic                      reset,
  if_pc_sequencer_if.master         bus,
  output state_t                    dbg_state
);

  state_t      state;
  logic [15:0] pc;
  logic        ifid_valid;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;
  logic [15:0] ifid_instr;

  logic        skid_load;
  logic        skid_clear;
  logic        skid_valid;
  logic [15:0] skid_pc;
  logic [15:0] skid_instr;

  logic        fetch_done;
  logic        ifid_free;

  assign fetch_done = (state == ST_FETCH) && bus.imem_ready;
  assign ifid_free  = !bus.stall || !ifid_valid;

  // Redirect flushes the skid entry as well as IF/ID.
  assign skid_load  = !bus.redirect_valid && fetch_done && !ifid_free;
  assign skid_clear = bus.redirect_valid || ((state == ST_HOLD) && !bus.stall);

  if_pc_sequencer_skid u_skid (
    .clock      (clock),
    .reset      (reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (pc),
    .load_instr (bus.imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_BOOT;
      pc           <= RESET_PC;
      ifid_valid   <= 1'b0;
      ifid_pc      <= 16'h0000;
      ifid_pc_next <= 16'h0000;
      ifid_instr   <= NOP_INSTR;
    end else if (bus.redirect_valid) begin
      state      <= ST_FETCH;
      pc         <= bus.redirect_target;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else begin
      case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH: begin
          if (bus.imem_ready) begin
            pc <= pc_inc(pc, PC_STEP);
            if (ifid_free) begin
              ifid_valid   <= 1'b1;
              ifid_pc      <= pc;
              ifid_pc_next <= pc_inc(pc, PC_STEP);
              ifid_instr   <= bus.imem_rdata;
            end else begin
              state <= ST_HOLD;
            end
          end else if (!bus.stall) begin
            ifid_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!bus.stall) begin
            state        <= ST_FETCH;
            ifid_valid   <= skid_valid;
            ifid_pc      <= skid_pc;
            ifid_pc_next <= pc_inc(skid_pc, PC_STEP);
            ifid_instr   <= skid_instr;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign bus.imem_req     = (state == ST_FETCH);
  assign bus.imem_addr    = pc;
  assign bus.ifid_valid   = ifid_valid;
  assign bus.ifid_pc      = ifid_pc;
  assign bus.ifid_pc_next = ifid_pc_next;
  assign bus.ifid_instr   = ifid_instr;
  assign dbg_state        = state;

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Directed bench for if_pc_sequencer: vector table for the main flow, hand sequences for reset corners.
module tb_if_pc_sequencer;
  import if_pc_sequencer_pkg::*;

  logic   clock = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_fail   = 0;

  if_pc_sequencer_if bus ();

  // Memory model: instruction word is a fixed scramble of its address.
  assign bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;

  if_pc_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        redirect;
    logic [15:0] target;
    logic        stall;
    logic        ready;
    state_t      e_state;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_next;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic rd, input logic [15:0] tg, input logic st,
                              input logic rdy, input state_t es, input logic er,
                              input logic [15:0] ea, input logic ev, input logic [15:0] ep,
                              input logic [15:0] en, input logic [15:0] ei);
    vec_t v;
    v.redirect = rd; v.target = tg; v.stall = st; v.ready = rdy;
    v.e_state = es; v.e_req = er; v.e_addr = ea; v.e_valid = ev;
    v.e_pc = ep; v.e_next = en; v.e_instr = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input state_t es, input logic er,
                           input logic [15:0] ea, input logic ev, input logic [15:0] ep,
                           input logic [15:0] en, input logic [15:0] ei);
    chk({tag, ".state"}, {14'b0, dbg_state}, {14'b0, es});
    chk({tag, ".imem_req"}, {15'b0, bus.imem_req}, {15'b0, er});
    chk({tag, ".imem_addr"}, bus.imem_addr, ea);
    chk({tag, ".ifid_valid"}, {15'b0, bus.ifid_valid}, {15'b0, ev});
    chk({tag, ".ifid_pc"}, bus.ifid_pc, ep);
    chk({tag, ".ifid_pc_next"}, bus.ifid_pc_next, en);
    chk({tag, ".ifid_instr"}, bus.ifid_instr, ei);
  endtask

  task automatic drive(input logic rd, input logic [15:0] tg, input logic st, input logic rdy);
    bus.redirect_valid  = rd;
    bus.redirect_target = tg;
    bus.stall           = st;
    bus.imem_ready      = rdy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Expected outputs are the registered state after the edge that consumes the inputs.
    vecs[0]  = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0004, 1, 16'h0000, 16'h0004, 16'hA5A5);
    vecs[2]  = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0008, 1, 16'h0004, 16'h0008, 16'hA5A1);
    vecs[3]  = mk(0, 16'h0000, 1, 1, ST_HOLD,  0, 16'h000C, 1, 16'h0004, 16'h0008, 16'hA5A1);
    vecs[4]  = mk(0, 16'h0000, 1, 1, ST_HOLD,  0, 16'h000C, 1, 16'h0004, 16'h0008, 16'hA5A1);
    vecs[5]  = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h000C, 1, 16'h0008, 16'h000C, 16'hA5AD);
    vecs[6]  = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0010, 1, 16'h000C, 16'h0010, 16'hA5A9);
    vecs[7]  = mk(0, 16'h0000, 0, 0, ST_FETCH, 1, 16'h0010, 0, 16'h000C, 16'h0010, 16'hA5A9);
    vecs[8]  = mk(0, 16'h0000, 0, 0, ST_FETCH, 1, 16'h0010, 0, 16'h000C, 16'h0010, 16'hA5A9);
    vecs[9]  = mk(0, 16'h0000, 0, 0, ST_FETCH, 1, 16'h0010, 0, 16'h000C, 16'h0010, 16'hA5A9);
    vecs[10] = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0014, 1, 16'h0010, 16'h0014, 16'hA5B5);
    vecs[11] = mk(0, 16'h0000, 1, 0, ST_FETCH, 1, 16'h0014, 1, 16'h0010, 16'h0014, 16'hA5B5);
    vecs[12] = mk(1, 16'h0040, 0, 1, ST_FETCH, 1, 16'h0040, 0, 16'h0010, 16'h0014, 16'h0000);
    vecs[13] = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0044, 1, 16'h0040, 16'h0044, 16'hA5E5);
    vecs[14] = mk(1, 16'hFFFC, 1, 1, ST_FETCH, 1, 16'hFFFC, 0, 16'h0040, 16'h0044, 16'h0000);
    vecs[15] = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0000, 1, 16'hFFFC, 16'h0000, 16'h5A59);
    vecs[16] = mk(0, 16'h0000, 0, 1, ST_FETCH, 1, 16'h0004, 1, 16'h0000, 16'h0004, 16'hA5A5);

    reset = 1'b1;
    drive(0, 16'h0000, 0, 1);
    step();
    step();
    check_all("reset", ST_BOOT, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);

    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].redirect, vecs[i].target, vecs[i].stall, vecs[i].ready);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_req, vecs[i].e_addr,
                vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_next, vecs[i].e_instr);
    end

    // Reset while HOLD owns a full skid entry.
    drive(0, 16'h0000, 1, 1);
    step();
    check_all("hold_pre", ST_HOLD, 0, 16'h0008, 1, 16'h0000, 16'h0004, 16'hA5A5);
    chk("hold_pre.skid_valid", {15'b0, dut.u_skid.valid}, 16'h0001);
    reset = 1'b1;
    step();
    check_all("hold_reset", ST_BOOT, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    chk("hold_reset.skid_valid", {15'b0, dut.u_skid.valid}, 16'h0000);
    reset = 1'b0;
    drive(0, 16'h0000, 0, 1);
    step();
    check_all("post_reset_boot", ST_FETCH, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    step();
    check_all("post_reset_fetch", ST_FETCH, 1, 16'h0004, 1, 16'h0000, 16'h0004, 16'hA5A5);

    // Redirect arriving during BOOT skips the boot cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1, 16'h0080, 0, 1);
    step();
    check_all("boot_redirect", ST_FETCH, 1, 16'h0080, 0, 16'h0000, 16'h0000, 16'h0000);
    drive(0, 16'h0000, 0, 1);
    step();
    check_all("boot_redirect_fetch", ST_FETCH, 1, 16'h0084, 1, 16'h0080, 16'h0084, 16'hA525);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
